// File: rtl/mem_arbiter_pkg.sv
// Shared LC-3b types used by the memory arbiter: word/line types and the
// arbiter state encoding.
package lc3b_types;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_line;

   typedef enum logic [1:0] {
      IDLE,
      GNT_I,
      GNT_D,
      RECOVER
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter_arb_select.sv
// Combinational grant picker for the memory arbiter.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (alternate on simultaneous
// requests); default build gives the D-cache fixed priority.
module arb_select (
   input  logic i_req,
   input  logic d_req,
   input  logic last_grant,   // 0 = I-cache granted last, 1 = D-cache
   output logic grant_i,
   output logic grant_d
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // On a tie, the side that was not granted last wins.
   always_comb begin
      grant_d = d_req & (~i_req | ~last_grant);
      grant_i = i_req & (~d_req | last_grant);
   end
`else
   logic unused_last_grant;
   assign unused_last_grant = last_grant;

   // Fixed priority: the D-cache always wins a tie.
   always_comb begin
      grant_d = d_req;
      grant_i = i_req & ~d_req;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the shared physical-memory port between I-cache and D-cache.
// One outstanding line transaction; command, address and wdata are latched at
// grant, resp/rdata are steered combinationally to the owner.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (adds a last_grant register).
module mem_arbiter
   import lc3b_types::*;
(
   input  logic     clk,
   input  logic     rst_n,

   input  logic     i_pmem_read,
   input  lc3b_word i_pmem_address,
   output lc3b_line i_pmem_rdata,
   output logic     i_pmem_resp,

   input  logic     d_pmem_read,
   input  logic     d_pmem_write,
   input  lc3b_word d_pmem_address,
   input  lc3b_line d_pmem_wdata,
   output lc3b_line d_pmem_rdata,
   output logic     d_pmem_resp,

   output logic     pmem_read,
   output logic     pmem_write,
   output lc3b_word pmem_address,
   output lc3b_line pmem_wdata,
   input  lc3b_line pmem_rdata,
   input  logic     pmem_resp
);

   arb_state_t state_q, state_d;
   logic       rd_q, rd_d;
   logic       wr_q, wr_d;
   lc3b_word   addr_q, addr_d;
   lc3b_line   wdata_q, wdata_d;

   logic       d_req;
   logic       grant_i, grant_d;
   logic       last_grant;

   // A simultaneous read+write from the D-cache is illegal; write wins.
   assign d_req = d_pmem_read | d_pmem_write;

   arb_select u_arb_select (
      .i_req      (i_pmem_read),
      .d_req      (d_req),
      .last_grant (last_grant),
      .grant_i    (grant_i),
      .grant_d    (grant_d)
   );

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_grant_q;

   // Remember which side won the most recent grant (reset: I-cache).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant_q <= 1'b0;
      end else if (state_q == IDLE && grant_d) begin
         last_grant_q <= 1'b1;
      end else if (state_q == IDLE && grant_i) begin
         last_grant_q <= 1'b0;
      end
   end

   assign last_grant = last_grant_q;
`else
   assign last_grant = 1'b0;
`endif

   // Next state, plus latching of the winning request at grant time.
   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      unique case (state_q)
         IDLE: begin
            if (grant_d) begin
               state_d = GNT_D;
               addr_d  = d_pmem_address;
               wr_d    = d_pmem_write;
               rd_d    = ~d_pmem_write;
               if (d_pmem_write) wdata_d = d_pmem_wdata;
            end else if (grant_i) begin
               state_d = GNT_I;
               addr_d  = i_pmem_address;
               wr_d    = 1'b0;
               rd_d    = 1'b1;
            end
         end
         GNT_I, GNT_D: begin
            if (pmem_resp) begin
               state_d = RECOVER;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
            end
         end
         RECOVER: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and latched port command registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Port is driven only from latched values; resp/rdata pass straight through.
   always_comb begin
      pmem_read    = rd_q;
      pmem_write   = wr_q;
      pmem_address = addr_q;
      pmem_wdata   = wdata_q;
      i_pmem_resp  = (state_q == GNT_I) & pmem_resp;
      d_pmem_resp  = (state_q == GNT_D) & pmem_resp;
      i_pmem_rdata = pmem_rdata;
      d_pmem_rdata = pmem_rdata;
   end

endmodule
